// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared definitions for the framebuffer loader: command
//                opcodes, loader FSM state encoding and the RGB565 pixel type.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    // Command opcodes carried in word_data[15:12] of a command word.
    localparam logic [3:0] c_OP_SET_ADDR = 4'h1;
    localparam logic [3:0] c_OP_WRITE    = 4'h2;
    localparam logic [3:0] c_OP_FILL     = 4'h3;
    localparam logic [3:0] c_OP_SWAP     = 4'h4;

    typedef enum logic [1:0] {
        ST_CMD         = 2'd0,
        ST_WRITE       = 2'd1,
        ST_FILL_COLOUR = 2'd2,
        ST_FILL_RUN    = 2'd3
    } state_t;

    // RGB565 pixel: R[15:11] G[10:5] B[4:0]
    typedef logic [15:0] pixel_t;

    function automatic logic [3:0] get_opcode(input pixel_t word);
        return word[15:12];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_loader_if
//  Description : Bundles the SPI word input, the frame_sync input and the
//                framebuffer write/bank/status outputs of the loader.
//                master : the loader (consumes words, drives the write port)
//                slave  : the environment (SPI front end, scanout, RAM)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fb_loader_if import fb_pkg::*; #(
    parameter int ADDR_WIDTH = 11
) ();

    pixel_t                  word_data;
    logic                    word_strobe;
    logic                    frame_sync;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    pixel_t                  wr_data;
    logic                    wr_bank;
    logic                    disp_bank;
    logic                    swap_pending;
    logic                    busy;
    logic                    overrun;

    modport master (
        input  word_data, word_strobe, frame_sync,
        output wr_en, wr_addr, wr_data, wr_bank, disp_bank,
               swap_pending, busy, overrun
    );

    modport slave (
        output word_data, word_strobe, frame_sync,
        input  wr_en, wr_addr, wr_data, wr_bank, disp_bank,
               swap_pending, busy, overrun
    );

endinterface
`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fb_swap_ctrl
//  Description : Double-buffer bank control. A swap request is latched as
//                pending and taken on the next frame_sync, so the scanout
//                never changes bank mid-frame.
//  Ports       : clk, reset_n    - clock, async active-low reset
//                swap_req        - one-cycle SWAP command decode
//                frame_sync      - end-of-frame pulse from scanout
//                disp_bank       - bank the scanout reads
//                swap_pending    - swap requested, not yet taken
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_swap_ctrl (
    input  wire  clk,
    input  wire  reset_n,
    input  wire  swap_req,
    input  wire  frame_sync,
    output logic disp_bank,
    output logic swap_pending
);

    logic r_disp_bank;
    logic r_swap_pending;

    // Only a swap that was already pending before this edge can be taken;
    // a request coinciding with frame_sync just arms the next frame.
    // A request while pending is already set changes nothing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_bank    <= 1'b0;
            r_swap_pending <= 1'b0;
        end else if (frame_sync && r_swap_pending) begin
            r_disp_bank    <= ~r_disp_bank;
            r_swap_pending <= 1'b0;
        end else if (swap_req) begin
            r_swap_pending <= 1'b1;
        end
    end

    assign disp_bank    = r_disp_bank;
    assign swap_pending = r_swap_pending;

endmodule
`default_nettype wire

// File: rtl/fb_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fb_loader
//  Description : Decodes 16-bit SPI command/pixel words into framebuffer
//                writes (SET_ADDR, WRITE burst, FILL run) and requests
//                double-buffer swaps synchronised to frame_sync.
//  Ports       : clk      - system clock
//                reset_n  - async active-low reset
//                bus      - fb_loader_if.master (word input, frame_sync,
//                           registered write port, bank and status flags)
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_loader import fb_pkg::*; #(
    parameter int ADDR_WIDTH = 11
) (
    input  wire          clk,
    input  wire          reset_n,
    fb_loader_if.master  bus
);

    localparam logic [ADDR_WIDTH-1:0] c_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ZERO = '0;

    state_t                r_state,   w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,    w_addr_nxt;
    logic [ADDR_WIDTH-1:0] r_count,   w_count_nxt;
    pixel_t                r_colour,  w_colour_nxt;
    logic                  r_wr_en,   w_wr_en_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
    pixel_t                r_wr_data, w_wr_data_nxt;
    logic                  r_overrun, w_overrun_nxt;
    logic                  w_swap_req;
    logic                  w_disp_bank;
    logic                  w_swap_pending;

    logic [3:0]            w_opcode;
    logic [ADDR_WIDTH-1:0] w_arg;
    logic                  w_last;

    assign w_opcode = get_opcode(bus.word_data);
    assign w_arg    = bus.word_data[ADDR_WIDTH-1:0];
    // Count is always >= 1 in WRITE/FILL_RUN, so "1" means this is the final write.
    assign w_last   = (r_count == c_ONE);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_CMD;
            r_addr    <= '0;
            r_count   <= '0;
            r_colour  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_count   <= w_count_nxt;
            r_colour  <= w_colour_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath decode. wr_addr/wr_data default to their held
    // value so the write port is stable whenever wr_en is low.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_count_nxt   = r_count;
        w_colour_nxt  = r_colour;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_overrun_nxt = 1'b0;
        w_swap_req    = 1'b0;

        unique case (r_state)
            ST_CMD: begin
                if (bus.word_strobe) begin
                    case (w_opcode)
                        c_OP_SET_ADDR: w_addr_nxt = w_arg;
                        c_OP_WRITE: begin
                            if (w_arg != c_ZERO) begin
                                w_count_nxt = w_arg;
                                w_state_nxt = ST_WRITE;
                            end
                        end
                        c_OP_FILL: begin
                            if (w_arg != c_ZERO) begin
                                w_count_nxt = w_arg;
                                w_state_nxt = ST_FILL_COLOUR;
                            end
                        end
                        c_OP_SWAP: w_swap_req = 1'b1;
                        default: ;  // reserved opcodes are ignored
                    endcase
                end
            end

            ST_WRITE: begin
                if (bus.word_strobe) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_addr;
                    w_wr_data_nxt = bus.word_data;
                    w_addr_nxt    = r_addr + c_ONE;
                    w_count_nxt   = r_count - c_ONE;
                    if (w_last) begin
                        w_state_nxt = ST_CMD;
                    end
                end
            end

            ST_FILL_COLOUR: begin
                if (bus.word_strobe) begin
                    w_colour_nxt = bus.word_data;
                    w_state_nxt  = ST_FILL_RUN;
                end
            end

            ST_FILL_RUN: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_addr;
                w_wr_data_nxt = r_colour;
                w_addr_nxt    = r_addr + c_ONE;
                w_count_nxt   = r_count - c_ONE;
                // The run owns the write port every cycle, so an incoming
                // word has nowhere to go and is dropped.
                w_overrun_nxt = bus.word_strobe;
                if (w_last) begin
                    w_state_nxt = ST_CMD;
                end
            end

            default: w_state_nxt = ST_CMD;
        endcase
    end

    // ------------------------------------------------------------------
    // Bank control
    // ------------------------------------------------------------------
    fb_swap_ctrl u_swap_ctrl (
        .clk          (clk),
        .reset_n      (reset_n),
        .swap_req     (w_swap_req),
        .frame_sync   (bus.frame_sync),
        .disp_bank    (w_disp_bank),
        .swap_pending (w_swap_pending)
    );

    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    // The back bank is always the one not on display, so a write lands in
    // whichever bank is hidden at the moment it is issued.
    assign bus.wr_bank      = ~w_disp_bank;
    assign bus.disp_bank    = w_disp_bank;
    assign bus.swap_pending = w_swap_pending;
    assign bus.busy         = (r_state != ST_CMD);
    assign bus.overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fb_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_loader
//  Description : Self-checking bench for fb_loader. Expected framebuffer
//                writes (cycle, bank, address, data) are queued when the
//                causing word is driven and compared as writes appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_loader;
    import fb_pkg::*;

    localparam int ADDR_WIDTH = 11;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    fb_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    fb_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    cyc;
        logic                  bank;
        logic [ADDR_WIDTH-1:0] addr;
        logic [15:0]           data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   ov_count = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.overrun) ov_count++;
            if (bus.wr_en) begin
                if (sb_q.size() == 0) begin
                    check_value("unexpected_write", {21'd0, bus.wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_value("wr_addr",  {21'd0, bus.wr_addr}, {21'd0, e.addr});
                    check_value("wr_data",  {16'd0, bus.wr_data}, {16'd0, e.data});
                    check_value("wr_bank",  {31'd0, bus.wr_bank}, {31'd0, e.bank});
                    check_value("wr_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_word(input logic [15:0] d);
        @(negedge clk);
        bus.word_data   = d;
        bus.word_strobe = 1'b1;
        @(negedge clk);
        bus.word_strobe = 1'b0;
    endtask

    // A pixel strobe whose write must appear exactly one clk later.
    task automatic drive_pixel(input logic [15:0] d, input logic [ADDR_WIDTH-1:0] a,
                               input logic b);
        @(negedge clk);
        bus.word_data   = d;
        bus.word_strobe = 1'b1;
        sb_q.push_back('{cyc + 1, b, a, d});
        @(negedge clk);
        bus.word_strobe = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        bus.frame_sync = 1'b1;
        @(negedge clk);
        bus.frame_sync = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_wr_en"},   {31'd0, bus.wr_en},        32'd0);
        check_value({tag, "_wr_addr"}, {21'd0, bus.wr_addr},      32'd0);
        check_value({tag, "_wr_data"}, {16'd0, bus.wr_data},      32'd0);
        check_value({tag, "_disp"},    {31'd0, bus.disp_bank},    32'd0);
        check_value({tag, "_wr_bank"}, {31'd0, bus.wr_bank},      32'd1);
        check_value({tag, "_pending"}, {31'd0, bus.swap_pending}, 32'd0);
        check_value({tag, "_busy"},    {31'd0, bus.busy},         32'd0);
        check_value({tag, "_overrun"}, {31'd0, bus.overrun},      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.word_data   = '0;
        bus.word_strobe = 1'b0;
        bus.frame_sync  = 1'b0;
        reset_n         = 1'b0;

        // Reset values
        idle(3);
        check_reset_outputs("rst");
        @(negedge clk) reset_n = 1'b1;
        idle(2);

        // Three-pixel burst
        drive_word(16'h1010);
        drive_word(16'h2003);
        check_value("burst_busy", {31'd0, bus.busy}, 32'd1);
        drive_pixel(16'hF800, 11'h010, 1'b1);
        drive_pixel(16'h07E0, 11'h011, 1'b1);
        drive_pixel(16'h001F, 11'h012, 1'b1);
        check_value("burst_idle", {31'd0, bus.busy}, 32'd0);
        idle(2);
        check_value("hold_wr_en",   {31'd0, bus.wr_en},   32'd0);
        check_value("hold_wr_addr", {21'd0, bus.wr_addr}, 32'h012);
        check_value("hold_wr_data", {16'd0, bus.wr_data}, 32'h001F);

        // Address wrap
        drive_word(16'h17FF);
        drive_word(16'h2002);
        drive_pixel(16'hAAAA, 11'h7FF, 1'b1);
        drive_pixel(16'h5555, 11'h000, 1'b1);
        check_value("wrap_idle", {31'd0, bus.busy}, 32'd0);

        // Zero-length WRITE/FILL and reserved opcodes are no-ops
        drive_word(16'h2000);
        check_value("write0_busy", {31'd0, bus.busy}, 32'd0);
        drive_word(16'h3000);
        check_value("fill0_busy", {31'd0, bus.busy}, 32'd0);
        drive_word(16'h0123);
        drive_word(16'h5FFF);
        drive_word(16'hFABC);
        check_value("ign_busy",    {31'd0, bus.busy},         32'd0);
        check_value("ign_pending", {31'd0, bus.swap_pending}, 32'd0);
        drive_word(16'h2001);
        drive_pixel(16'h1357, 11'h001, 1'b1);

        // FILL of 4 with a stray word during the run
        drive_word(16'h1000);
        drive_word(16'h3004);
        check_value("fill_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.word_data   = 16'hFFFF;
        bus.word_strobe = 1'b1;
        for (int i = 0; i < 4; i++)
            sb_q.push_back('{cyc + 2 + i, 1'b1, ADDR_WIDTH'(i), 16'hFFFF});
        @(negedge clk);
        bus.word_strobe = 1'b0;
        drive_word(16'h1005);
        idle(6);
        check_value("fill_overrun", ov_count, 1);
        check_value("fill_idle", {31'd0, bus.busy}, 32'd0);
        check_value("fill_done", sb_q.size(), 0);
        // The dropped SET_ADDR must not have moved the address counter.
        drive_word(16'h2001);
        drive_pixel(16'h2468, 11'h004, 1'b1);

        // SWAP then frame_sync
        drive_word(16'h4000);
        check_value("swap_pending", {31'd0, bus.swap_pending}, 32'd1);
        check_value("swap_disp0",   {31'd0, bus.disp_bank},    32'd0);
        idle(3);
        check_value("swap_wait",    {31'd0, bus.disp_bank},    32'd0);
        pulse_frame();
        check_value("swap_disp1",   {31'd0, bus.disp_bank},    32'd1);
        check_value("swap_wr_bank", {31'd0, bus.wr_bank},      32'd0);
        check_value("swap_clear",   {31'd0, bus.swap_pending}, 32'd0);
        drive_word(16'h2001);
        drive_pixel(16'h0F0F, 11'h005, 1'b0);

        // SWAP coincident with frame_sync: no toggle until the next frame
        @(negedge clk);
        bus.word_data   = 16'h4000;
        bus.word_strobe = 1'b1;
        bus.frame_sync  = 1'b1;
        @(negedge clk);
        bus.word_strobe = 1'b0;
        bus.frame_sync  = 1'b0;
        check_value("coin_disp",    {31'd0, bus.disp_bank},    32'd1);
        check_value("coin_pending", {31'd0, bus.swap_pending}, 32'd1);
        pulse_frame();
        check_value("coin_toggle",  {31'd0, bus.disp_bank},    32'd0);
        check_value("coin_clear",   {31'd0, bus.swap_pending}, 32'd0);

        // Repeated SWAP yields a single toggle
        drive_word(16'h4000);
        drive_word(16'h4000);
        pulse_frame();
        check_value("dbl_disp",  {31'd0, bus.disp_bank},    32'd1);
        check_value("dbl_clear", {31'd0, bus.swap_pending}, 32'd0);
        pulse_frame();
        check_value("dbl_once",  {31'd0, bus.disp_bank},    32'd1);

        // Reset in the middle of a 5-pixel WRITE
        drive_word(16'h1020);
        drive_word(16'h2005);
        drive_pixel(16'h1111, 11'h020, 1'b0);
        drive_pixel(16'h2222, 11'h021, 1'b0);
        @(negedge clk) reset_n = 1'b0;
        idle(1);
        check_reset_outputs("rst_mid");
        @(negedge clk) reset_n = 1'b1;
        idle(3);
        // Former pixel data now decodes as a command.
        drive_word(16'h1030);
        check_value("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        drive_word(16'h2001);
        drive_pixel(16'h3333, 11'h030, 1'b1);

        idle(4);
        check_value("sb_empty",   sb_q.size(), 0);
        check_value("ov_final",   ov_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_loader.md
FB_LOADER -- requirements
Module: fb_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning framebuffer pixel address width (64x32 panel).
REQ-002 SHALL have port clk  input  1  the single system clock; all state advances on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port word_data  input  16  received SPI word, valid only while word_strobe is high.
REQ-005 SHALL have port word_strobe  input  1  one-cycle pulse per received word, already synchronous to clk.
REQ-006 SHALL have port frame_sync  input  1  one-cycle pulse from scanout at the end of each displayed frame.
REQ-007 SHALL have port wr_en  output  1  framebuffer write enable.
REQ-008 SHALL have port wr_addr  output  ADDR_WIDTH  framebuffer write address.
REQ-009 SHALL have port wr_data  output  16  framebuffer write pixel (RGB565).
REQ-010 SHALL have port wr_bank  output  1  bank being written; always the inverse of disp_bank.
REQ-011 SHALL have port disp_bank  output  1  bank the scanout reads.
REQ-012 SHALL have port swap_pending  output  1  a swap has been requested but not yet taken.
REQ-013 SHALL have port busy  output  1  high in any state other than CMD.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse when a word is dropped.

Function
REQ-015 Command word layout SHALL be: opcode word_data[15:12], argument word_data[ADDR_WIDTH-1:0].
REQ-016 Opcode 0x1 SET_ADDR SHALL load the address counter with the argument and stay in CMD.
REQ-017 Opcode 0x2 WRITE SHALL load the remaining count with the argument and enter WRITE; if the argument is 0, the opcode is a no-op and the block stays in CMD.
REQ-018 In WRITE, each strobe SHALL produce one write at the address counter, then increment the address counter and decrement the count; when the count reaches 0 the block SHALL return to CMD.
REQ-019 Opcode 0x3 FILL SHALL load the count (0 is a no-op) and enter FILL_COLOUR; the next strobe SHALL latch the colour and enter FILL_RUN.
REQ-020 FILL_RUN SHALL issue one write per clk with the latched colour, incrementing the address counter, until the count reaches 0, then return to CMD.
REQ-021 A strobe arriving in FILL_RUN SHALL be dropped and SHALL pulse overrun in the following cycle.
REQ-022 Opcode 0x4 SWAP SHALL set swap_pending and stay in CMD.
REQ-023 Opcodes 0x0 and 0x5-0xF SHALL be ignored, with no state change and no overrun.
REQ-024 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; 2047+1 gives 0 at the default width.
REQ-025 wr_en/wr_addr/wr_data SHALL be registered, with wr_en high exactly one clk after the causing strobe (WRITE) or state cycle (FILL_RUN).
REQ-026 wr_data and wr_addr SHALL hold their last value while wr_en is low.
REQ-027 On frame_sync with swap_pending high, disp_bank SHALL toggle and swap_pending SHALL clear on the same edge.
REQ-028 If SWAP decode and frame_sync coincide with swap_pending low, the swap SHALL NOT be taken; swap_pending SHALL set, and the swap SHALL occur on the next frame_sync.
REQ-029 A SWAP received while swap_pending is already high SHALL have no additional effect.
REQ-030 wr_bank SHALL be sampled per write, so writes after a toggle target the new back bank.

Reset
REQ-031 While reset_n is low, the outputs SHALL be: wr_en=0, wr_addr=0, wr_data=0, disp_bank=0, wr_bank=1, swap_pending=0, busy=0, overrun=0.
REQ-032 While reset_n is low, the address counter SHALL be 0, the count SHALL be 0, and the state SHALL be CMD.
REQ-033 Reset asserted mid-WRITE or mid-FILL SHALL abort immediately; no further writes SHALL occur after reset_n rises until a new command arrives.

Structure
REQ-034 A shared package fb_pkg SHALL hold the opcode constants, the state enum (CMD, WRITE, FILL_COLOUR, FILL_RUN) and the RGB565 pixel typedef.
REQ-035 Bank/swap logic (REQ-027..030) SHALL be the sub-module fb_swap_ctrl; everything else SHALL be in one FSM plus counters.

Verification
REQ-036 Scenario: SET_ADDR 0x1010, WRITE 0x2003, pixels F800/07E0/001F -> writes (0x010,F800),(0x011,07E0),(0x012,001F) on wr_bank=1, each one clk after its strobe, then busy=0.
REQ-037 Scenario: SET_ADDR 0x17FF, WRITE 0x2002, pixels AAAA/5555 -> writes at 0x7FF then 0x000.
REQ-038 Scenario: FILL 0x3004, colour FFFF, plus a strobe during the run -> 4 consecutive writes at addresses 0..3, exactly one overrun pulse, and no extra write.
REQ-039 Scenario: SWAP with no frame_sync -> swap_pending=1 and disp_bank=0; then a frame_sync pulse -> disp_bank=1, wr_bank=0, swap_pending=0.
REQ-040 Scenario: SWAP strobe and frame_sync coincident -> no toggle that edge; toggle on the next frame_sync.
REQ-041 Scenario: reset_n pulsed low after 2 of 5 WRITE pixels -> all outputs at their reset values, and further pixel strobes decode as commands.
